smpl_iter: RTL and testbench
============================

// Module: smpl_iter
// PURPOSE
//  Sample iterator. Walks every subsample position of a triangle's snapped bounding box in raster order.
//  Emits one candidate sample per cycle, with the triangle and colour, to the sample test stage.
//  Sits between bbox (R13) and sampletest (R14 onward); it is the producer of the validSamp/sample stream
//  that the per-triangle hit-count scoreboards consume.
//  Also outputs a per-triangle sample count and a done pulse for scoreboard cross-checks.
// PARAMETERS
//  SIGFIG  24  bits in colour and position
//  RADIX   10  fraction bits in position
//  VERTS   3   vertices per triangle
//  AXIS    3   axes per vertex (x,y,z)
//  COLORS  3   colour channels
// PORTS
//  clk               in   1                       clock
//  rst               in   1                       synchronous active-low reset; 0 = reset
//  tri_R13S          in   [SIGFIG]x[VERTS][AXIS]  triangle vertices, signed fixed point
//  color_R13U        in   [SIGFIG]x[COLORS]       triangle colour
//  box_R13S          in   [SIGFIG]x[2][2]         [0]=LL(x,y), [1]=UR(x,y), already snapped to subsample grid
//  validTri_R13H     in   1                       triangle/box valid
//  subSample_RnnnnU  in   4                       one-hot MSAA: [0]=64x,[1]=16x,[2]=4x,[3]=1x
//  screen_RnnnnS     in   [SIGFIG]x[2]            screen w,h (informational, not clipped here)
//  halt_RnnnnL       in   1                       downstream ready, active-low halt (1 = advance)
//  halt_R13L         out  1                       upstream ready, active-low halt (1 = accept)
//  tri_R14S          out  [SIGFIG]x[VERTS][AXIS]  triangle held for current sample
//  color_R14U        out  [SIGFIG]x[COLORS]       colour held for current sample
//  sample_R14S       out  [SIGFIG]x[2]            sample x,y
//  validSamp_R14H    out  1                       sample valid
//  smplCnt_R14U      out  32                      samples emitted so far for current triangle, incl. this one
//  triDone_R14H      out  1                       high with the last sample of a triangle
// BEHAVIOUR
//  - Reset (rst==0 at posedge): state=WAIT, all outputs 0 except halt_R13L=1. Aborts any in-flight triangle.
//  - Step size ss = 1 << (RADIX - ss_w_lg2), ss_w_lg2 = 3/2/1/0 for subSample bit 0/1/2/3.
//    Priority is from bit 0. All-zero subSample is treated as 1x.
//  - FSM WAIT: halt_R13L=1. On validTri_R13H=1:
//    latch tri, colour, box; load sample=LL; cnt=1; go to TEST.
//    The first sample is valid on the next cycle (1-cycle latency).
//  - FSM TEST: validSamp_R14H=1. Advance only when halt_RnnnnL=1; otherwise hold all outputs unchanged.
//  - Advance order:
//    x+ss while x<UR.x;
//    else x=LL.x and y+ss while y<UR.y;
//    else last sample.
//    Compare signed and at full SIGFIG; no wrap beyond UR.
//  - last = (x==UR.x && y==UR.y); triDone_R14H = validSamp_R14H & last.
//  - halt_R13L = WAIT | (TEST & last & halt_RnnnnL). Back-to-back triangles therefore have no bubble:
//    - on an accept during the last sample, the new triangle loads directly and the state stays TEST;
//    - with no new triangle, the state goes to WAIT and validSamp drops next cycle.
//  - smplCnt increments by 1 per advance and reloads to 1 on a new triangle.
//    It saturates at 32'hFFFF_FFFF.
//  - A degenerate box (LL==UR) emits exactly 1 sample with triDone=1.
//  - Box inversion (UR<LL on either axis) is illegal upstream. The block then emits exactly 1 sample at LL
//    with triDone=1; it must not hang.
//  - tri/colour/box are stable in registers while in TEST, independent of R13 inputs.
//  - subSample_RnnnnU and screen_RnnnnS are quasi-static; a change mid-triangle is undefined.
// TESTING
//  1. 4x (4'b0100, ss=512), box (0,0)-(1024,1024), halt_RnnnnL=1
//     -> 9 samples: (0,0),(512,0),(1024,0),(0,512)..(1024,1024); triDone on the 9th; cnt=9.
//  2. 1x (4'b1000), box (0,0)-(3072,1024) -> 8 samples, x step 1024, one per cycle, cnt=8.
//  3. Degenerate box (2048,2048)-(2048,2048) -> single sample (2048,2048), triDone=1, cnt=1, WAIT next cycle.
//  4. Scenario 1 with halt_RnnnnL=0 for 3 cycles after sample 4
//     -> sample (0,512) held 4 cycles, halt_R13L=0, no sample dropped or duplicated, total 9.
//  5. Two triangles, validTri held 1
//     -> second triangle's first sample directly follows the first's last sample, no gap, cnt reloads to 1.
//  6. rst=0 during sample 5 of scenario 1 -> next cycle validSamp=0, triDone=0, cnt=0, halt_R13L=1, state WAIT.

Source files
------------

// File: rtl/smpl_iter.sv
// smpl_iter - sample iterator.
// Walks every subsample position of a triangle's snapped bounding box in
// raster order and emits one candidate sample per cycle, with the triangle
// and colour, toward the sample test stage.
//
// Ports
//   clk               clock
//   rst               synchronous active-low reset (0 = reset)
//   tri_R13S          triangle vertices [vert][axis], signed fixed point
//   color_R13U        triangle colour [channel]
//   box_R13S          bounding box [corner][axis], corner 0 = LL, 1 = UR
//   validTri_R13H     triangle/box valid
//   subSample_RnnnnU  one-hot MSAA select: [0]=64x [1]=16x [2]=4x [3]=1x
//   screen_RnnnnS     screen w,h (informational only)
//   halt_RnnnnL       downstream ready (1 = advance)
//   halt_R13L         upstream ready (1 = accept)
//   tri_R14S          triangle held for the current sample
//   color_R14U        colour held for the current sample
//   sample_R14S       sample [axis]
//   validSamp_R14H    sample valid
//   smplCnt_R14U      samples emitted so far for this triangle, incl. this one
//   triDone_R14H      high with the last sample of a triangle
//
// state | meaning
// ------+--------------------------------------------------------------
// WAIT  | idle, ready for a triangle, no sample on the output
// TEST  | presenting a sample; advances when downstream is ready
module smpl_iter #(
  parameter int SIGFIG = 24,
  parameter int RADIX  = 10,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]    tri_R13S,
  input  logic [COLORS-1:0][SIGFIG-1:0]             color_R13U,
  input  logic [1:0][1:0][SIGFIG-1:0]               box_R13S,
  input  logic                                      validTri_R13H,
  input  logic [3:0]                                subSample_RnnnnU,
  input  logic [1:0][SIGFIG-1:0]                    screen_RnnnnS,
  input  logic                                      halt_RnnnnL,
  output logic                                      halt_R13L,
  output logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]    tri_R14S,
  output logic [COLORS-1:0][SIGFIG-1:0]             color_R14U,
  output logic [1:0][SIGFIG-1:0]                    sample_R14S,
  output logic                                      validSamp_R14H,
  output logic [31:0]                               smplCnt_R14U,
  output logic                                      triDone_R14H
);

  typedef enum logic {WAIT = 1'b0, TEST = 1'b1} state_t;

  state_t                                r_state;
  state_t                                w_state_nxt;
  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] r_tri;
  logic [COLORS-1:0][SIGFIG-1:0]          r_color;
  logic [1:0][1:0][SIGFIG-1:0]            r_box;
  logic signed [SIGFIG-1:0]               r_x, r_y;
  logic signed [SIGFIG-1:0]               w_x_nxt, w_y_nxt;
  logic [31:0]                            r_cnt, w_cnt_nxt, w_cnt_inc;
  logic signed [SIGFIG-1:0]               w_ss;
  logic signed [SIGFIG-1:0]               w_llx, w_lly, w_urx, w_ury;
  logic                                   w_x_more, w_y_more, w_last;
  logic                                   w_load;
  logic                                   w_unused;

  // Screen size is carried for downstream stages only; nothing is clipped here.
  assign w_unused = ^screen_RnnnnS;

  assign w_llx = r_box[0][0];
  assign w_lly = r_box[0][1];
  assign w_urx = r_box[1][0];
  assign w_ury = r_box[1][1];

  // Step is one subsample pitch; lowest set bit wins, no bits set means 1x.
  always_comb begin
    w_ss = SIGFIG'(1) << RADIX;
    if (subSample_RnnnnU[0])      w_ss = SIGFIG'(1) << (RADIX - 3);
    else if (subSample_RnnnnU[1]) w_ss = SIGFIG'(1) << (RADIX - 2);
    else if (subSample_RnnnnU[2]) w_ss = SIGFIG'(1) << (RADIX - 1);
  end

  // "Last" means no further advance is possible. For a legal snapped box this
  // is exactly x==UR.x && y==UR.y; for an inverted box it makes the LL sample
  // the only one, so the walk cannot run away.
  assign w_x_more = (r_x < w_urx);
  assign w_y_more = (r_y < w_ury);
  assign w_last   = !w_x_more && !w_y_more;

  assign w_cnt_inc = (r_cnt == 32'hFFFF_FFFF) ? r_cnt : r_cnt + 32'd1;

  assign halt_R13L = (r_state == WAIT) || (w_last && halt_RnnnnL);
  assign w_load    = halt_R13L && validTri_R13H;

  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_cnt_nxt   = r_cnt;
    if (w_load) begin
      w_state_nxt = TEST;
      w_x_nxt     = box_R13S[0][0];
      w_y_nxt     = box_R13S[0][1];
      w_cnt_nxt   = 32'd1;
    end else if (r_state == TEST && halt_RnnnnL) begin
      if (w_last) begin
        w_state_nxt = WAIT;
      end else if (w_x_more) begin
        w_x_nxt   = r_x + w_ss;
        w_cnt_nxt = w_cnt_inc;
      end else begin
        w_x_nxt   = w_llx;
        w_y_nxt   = r_y + w_ss;
        w_cnt_nxt = w_cnt_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= WAIT;
      r_tri   <= '0;
      r_color <= '0;
      r_box   <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_load) begin
        r_tri   <= tri_R13S;
        r_color <= color_R13U;
        r_box   <= box_R13S;
      end
    end
  end

  assign tri_R14S       = r_tri;
  assign color_R14U     = r_color;
  assign sample_R14S[0] = r_x;
  assign sample_R14S[1] = r_y;
  assign validSamp_R14H = (r_state == TEST);
  assign smplCnt_R14U   = r_cnt;
  assign triDone_R14H   = validSamp_R14H && w_last;

endmodule

// File: tb/tb_smpl_iter.sv
module tb_smpl_iter;

  logic                    clk;
  logic                    rst;
  logic [2:0][2:0][23:0]   tri_R13S;
  logic [2:0][23:0]        color_R13U;
  logic [1:0][1:0][23:0]   box_R13S;
  logic                    validTri_R13H;
  logic [3:0]              subSample_RnnnnU;
  logic [1:0][23:0]        screen_RnnnnS;
  logic                    halt_RnnnnL;
  logic                    halt_R13L;
  logic [2:0][2:0][23:0]   tri_R14S;
  logic [2:0][23:0]        color_R14U;
  logic [1:0][23:0]        sample_R14S;
  logic                    validSamp_R14H;
  logic [31:0]             smplCnt_R14U;
  logic                    triDone_R14H;

  smpl_iter dut (
    .clk              (clk),
    .rst              (rst),
    .tri_R13S         (tri_R13S),
    .color_R13U       (color_R13U),
    .box_R13S         (box_R13S),
    .validTri_R13H    (validTri_R13H),
    .subSample_RnnnnU (subSample_RnnnnU),
    .screen_RnnnnS    (screen_RnnnnS),
    .halt_RnnnnL      (halt_RnnnnL),
    .halt_R13L        (halt_R13L),
    .tri_R14S         (tri_R14S),
    .color_R14U       (color_R14U),
    .sample_R14S      (sample_R14S),
    .validSamp_R14H   (validSamp_R14H),
    .smplCnt_R14U     (smplCnt_R14U),
    .triDone_R14H     (triDone_R14H)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          x;
    int          y;
    int          cnt;
    bit          done;
    logic [71:0] col;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_pop  = 0;
  int   n_stall = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int ss_of(input logic [3:0] sub);
    if (sub[0]) return 128;
    if (sub[1]) return 256;
    if (sub[2]) return 512;
    return 1024;
  endfunction

  // Reference raster walk: x row inclusive of UR, then next row.
  task automatic push_tri(input int llx, input int lly, input int urx, input int ury,
                          input int ss, input logic [71:0] col);
    exp_t e;
    int   x, y, c;
    c = 0;
    y = lly;
    forever begin
      x = llx;
      forever begin
        c++;
        e.x = x; e.y = y; e.cnt = c; e.col = col;
        e.done = (x >= urx) && (y >= ury);
        q.push_back(e);
        if (x >= urx) break;
        x += ss;
      end
      if (y >= ury) break;
      y += ss;
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && validSamp_R14H) begin
      if (!halt_RnnnnL) begin
        n_stall++;
        chk("stall_halt13", halt_R13L, 1'b0);
        if (q.size() > 0) begin
          chk("stall_hold_x", sample_R14S[0], q[0].x[23:0]);
          chk("stall_hold_y", sample_R14S[1], q[0].y[23:0]);
        end
      end else if (q.size() == 0) begin
        chk("sb_extra_sample", 1'b1, 1'b0);
      end else begin
        exp_t e;
        e = q.pop_front();
        n_pop++;
        chk("samp_x", sample_R14S[0], e.x[23:0]);
        chk("samp_y", sample_R14S[1], e.y[23:0]);
        chk("samp_cnt", smplCnt_R14U, e.cnt);
        chk("samp_done", triDone_R14H, e.done);
        chk("samp_color", color_R14U, e.col);
      end
    end
  end

  // Called at posedge+1; returns at the following posedge+1 with the
  // triangle loaded and the R13 inputs scrambled.
  task automatic launch(input int llx, input int lly, input int urx, input int ury,
                        input logic [3:0] sub, input logic [71:0] col);
    subSample_RnnnnU = sub;
    box_R13S[0][0] = llx[23:0];
    box_R13S[0][1] = lly[23:0];
    box_R13S[1][0] = urx[23:0];
    box_R13S[1][1] = ury[23:0];
    color_R13U = col;
    validTri_R13H = 1'b1;
    push_tri(llx, lly, urx, ury, ss_of(sub), col);
    @(posedge clk); #1;
    validTri_R13H = 1'b0;
    color_R13U = {$urandom(), $urandom(), $urandom()};
    box_R13S = {$urandom(), $urandom(), $urandom()};
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    if (q.size() != 0) begin
      chk({tag, "_timeout"}, q.size(), 0);
      q.delete();
    end
  endtask

  initial begin
    int gaps;
    rst = 1'b0;
    tri_R13S = '0;
    color_R13U = '0;
    box_R13S = '0;
    validTri_R13H = 1'b0;
    subSample_RnnnnU = 4'b0100;
    screen_RnnnnS = {24'd4096, 24'd4096};
    halt_RnnnnL = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_valid", validSamp_R14H, 1'b0);
    chk("rst_done", triDone_R14H, 1'b0);
    chk("rst_cnt", smplCnt_R14U, 32'd0);
    chk("rst_halt13", halt_R13L, 1'b1);
    chk("rst_sample", sample_R14S, 48'd0);
    mon_en = 1'b1;
    @(posedge clk); #1;

    // 4x 3x3 grid
    tri_R13S = {9{24'h000155}};
    n_pop = 0;
    launch(0, 0, 1024, 1024, 4'b0100, {24'h123456, 24'hABCDEF, 24'h0F0F0F});
    drain("s1");
    chk("s1_total", n_pop, 9);
    @(negedge clk);
    chk("s1_idle", validSamp_R14H, 1'b0);
    @(posedge clk); #1;

    // 1x 4x2 grid
    n_pop = 0;
    launch(0, 0, 3072, 1024, 4'b1000, {24'h111111, 24'h222222, 24'h333333});
    drain("s2");
    chk("s2_total", n_pop, 8);
    @(posedge clk); #1;

    // degenerate box
    n_pop = 0;
    launch(2048, 2048, 2048, 2048, 4'b0100, {24'h444444, 24'h555555, 24'h666666});
    drain("s3");
    chk("s3_total", n_pop, 1);
    @(negedge clk);
    chk("s3_idle", validSamp_R14H, 1'b0);
    chk("s3_halt13", halt_R13L, 1'b1);
    @(posedge clk); #1;

    // downstream stall on sample 4 for 3 cycles
    n_pop = 0;
    n_stall = 0;
    launch(0, 0, 1024, 1024, 4'b0100, {24'h777777, 24'h888888, 24'h999999});
    repeat (3) @(posedge clk);
    #1 halt_RnnnnL = 1'b0;
    repeat (3) @(posedge clk);
    #1 halt_RnnnnL = 1'b1;
    drain("s4");
    chk("s4_total", n_pop, 9);
    chk("s4_stalls", n_stall, 3);
    @(posedge clk); #1;

    // back-to-back triangles, validTri held
    n_pop = 0;
    gaps = 0;
    launch(0, 0, 1024, 1024, 4'b0100, {24'hAAAAAA, 24'hBBBBBB, 24'hCCCCCC});
    box_R13S[0][0] = 24'd2048;
    box_R13S[0][1] = 24'd0;
    box_R13S[1][0] = 24'd3072;
    box_R13S[1][1] = 24'd512;
    color_R13U = {24'hDDDDDD, 24'hEEEEEE, 24'hFFFFFF};
    validTri_R13H = 1'b1;
    push_tri(2048, 0, 3072, 512, 512, {24'hDDDDDD, 24'hEEEEEE, 24'hFFFFFF});
    for (int n = 0; n < 200 && q.size() != 0; n++) begin
      @(negedge clk);
      if (!validSamp_R14H) gaps++;
      if (validTri_R13H && halt_R13L) begin
        @(posedge clk); #1;
        validTri_R13H = 1'b0;
      end else begin
        #1;
      end
    end
    validTri_R13H = 1'b0;
    chk("s5_drained", q.size(), 0);
    q.delete();
    chk("s5_total", n_pop, 15);
    chk("s5_gaps", gaps, 0);
    @(posedge clk); #1;

    // inverted box: single sample at LL
    n_pop = 0;
    launch(1024, 1024, 0, 0, 4'b0100, {24'h010101, 24'h020202, 24'h030303});
    drain("inv");
    chk("inv_total", n_pop, 1);
    @(posedge clk); #1;

    // 64x
    n_pop = 0;
    launch(0, 0, 256, 128, 4'b0001, {24'h0A0A0A, 24'h0B0B0B, 24'h0C0C0C});
    drain("s64");
    chk("s64_total", n_pop, 6);
    @(posedge clk); #1;

    // 16x with 1x bit also set: lower bit wins
    n_pop = 0;
    launch(0, 0, 512, 0, 4'b1010, {24'h0D0D0D, 24'h0E0E0E, 24'h0F0F0F});
    drain("s16");
    chk("s16_total", n_pop, 3);
    @(posedge clk); #1;

    // no subsample bit: 1x
    n_pop = 0;
    launch(0, 0, 1024, 0, 4'b0000, {24'h303030, 24'h404040, 24'h505050});
    drain("s0");
    chk("s0_total", n_pop, 2);
    @(posedge clk); #1;

    // reset during sample 5
    n_pop = 0;
    launch(0, 0, 1024, 1024, 4'b0100, {24'h606060, 24'h707070, 24'h808080});
    for (int n = 0; n < 50 && q.size() > 5; n++) begin
      @(negedge clk); #1;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("s6_valid", validSamp_R14H, 1'b0);
    chk("s6_done", triDone_R14H, 1'b0);
    chk("s6_cnt", smplCnt_R14U, 32'd0);
    chk("s6_halt13", halt_R13L, 1'b1);
    chk("s6_popped", n_pop, 5);
    q.delete();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("s6_stays_idle", validSamp_R14H, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
